// File: rtl/iomem_arb_if.sv
// rtl/iomem_arb_if.sv - CPU iomem bus and shared slave bus bundle for iomem_arb
interface iomem_arb_if #(
  parameter int NSLV = 4
);
  logic                   iomem_valid;
  logic [31:0]            iomem_addr;
  logic [3:0]             iomem_wstrb;
  logic [31:0]            iomem_wdata;
  logic                   iomem_ready;
  logic [31:0]            iomem_rdata;
  logic [NSLV-1:0]        s_valid;
  logic [19:0]            s_addr;
  logic [3:0]             s_wstrb;
  logic [31:0]            s_wdata;
  logic [NSLV-1:0]        s_ready;
  logic [32*NSLV-1:0]     s_rdata;

  // the arbiter's view: it serves the CPU and drives the slaves
  modport slave (
    input  iomem_valid, iomem_addr, iomem_wstrb, iomem_wdata, s_ready, s_rdata,
    output iomem_ready, iomem_rdata, s_valid, s_addr, s_wstrb, s_wdata
  );

  modport master (
    output iomem_valid, iomem_addr, iomem_wstrb, iomem_wdata, s_ready, s_rdata,
    input  iomem_ready, iomem_rdata, s_valid, s_addr, s_wstrb, s_wdata
  );
endinterface

// File: rtl/iomem_arb.sv
// rtl/iomem_arb.sv - iomem request decoder/arbiter onto four slaves with timeout and error tracking
module iomem_arb #(
  parameter int          NSLV     = 4,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk_bufg,
  input  logic        resetn,
  iomem_arb_if.slave  bus,
  output logic [7:0]  err_count,
  output logic [31:0] err_addr
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t          state;
  logic [7:0]      cnt;
  logic [1:0]      idx;
  logic [31:0]     req_addr;
  logic [3:0]      req_wstrb;
  logic [31:0]     req_wdata;
  logic [NSLV-1:0] sel;
  logic            ready_q;
  logic [31:0]     rdata_q;

  logic claim;
  logic dec_err;

  assign claim   = bus.iomem_valid && (bus.iomem_addr[31:24] == 8'h03);
  assign dec_err = |bus.iomem_addr[23:22];

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign bus.s_valid     = sel;
  assign bus.s_addr      = req_addr[19:0];
  assign bus.s_wstrb     = req_wstrb;
  assign bus.s_wdata     = req_wdata;

  always_ff @(posedge clk_bufg) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      idx       <= 2'd0;
      req_addr  <= 32'd0;
      req_wstrb <= 4'd0;
      req_wdata <= 32'd0;
      sel       <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= 32'd0;
      err_count <= 8'd0;
      err_addr  <= 32'd0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (claim) begin
            if (dec_err) begin
              rdata_q   <= ERR_DATA;
              ready_q   <= 1'b1;
              err_addr  <= bus.iomem_addr;
              err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
              state     <= DONE;
            end else begin
              req_addr  <= bus.iomem_addr;
              req_wstrb <= bus.iomem_wstrb;
              req_wdata <= bus.iomem_wdata;
              idx       <= bus.iomem_addr[21:20];
              sel       <= NSLV'(1) << bus.iomem_addr[21:20];
              cnt       <= 8'd0;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // ready is checked first so a reply on the last allowed cycle is not an error
          if (bus.s_ready[idx]) begin
            rdata_q <= bus.s_rdata[32*idx +: 32];
            sel     <= '0;
            ready_q <= 1'b1;
            state   <= DONE;
          end else if (cnt == TO_LAST) begin
            rdata_q   <= ERR_DATA;
            sel       <= '0;
            ready_q   <= 1'b1;
            err_addr  <= req_addr;
            err_count <= (err_count == 8'hFF) ? err_count : err_count + 8'd1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
